// File: rtl/hazard_unit_v2_pkg.sv
// Shared hazard-unit definitions: FSM state encodings and the stall/flush
// vectors each state drives into the pipeline.
package hazard_pkg;

    typedef enum logic [3:0] {
        ST_RUN      = 4'd0,
        ST_EXC      = 4'd1,
        ST_EXC_WAIT = 4'd2,
        ST_MEM_WAIT = 4'd3,
        ST_MD_BUSY  = 4'd4,
        ST_MD_TAIL  = 4'd5,
        ST_LOAD_USE = 4'd6,
        ST_BR_DEP   = 4'd7,
        ST_IF_WAIT  = 4'd8
    } hz_state_t;

    // stall bits are {F,D,E,M,W}; flush bits are {D,E,M,W}
    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_ALL  = 5'b11111;
    localparam logic [4:0] STALL_MEM  = 5'b11110;
    localparam logic [4:0] STALL_MD   = 5'b11100;
    localparam logic [4:0] STALL_ID   = 5'b11000;
    localparam logic [4:0] STALL_IF   = 5'b10000;

    localparam logic [3:0] FLUSH_NONE = 4'b0000;
    localparam logic [3:0] FLUSH_ALL  = 4'b1111;
    localparam logic [3:0] FLUSH_W    = 4'b0001;
    localparam logic [3:0] FLUSH_M    = 4'b0010;
    localparam logic [3:0] FLUSH_E    = 4'b0100;
    localparam logic [3:0] FLUSH_D    = 4'b1000;

    typedef struct packed {
        logic [4:0] stall;
        logic [3:0] flush;
    } hz_ctrl_t;

    function automatic hz_ctrl_t ctrl_of(input hz_state_t s);
        hz_ctrl_t c;
        c = '{stall: STALL_NONE, flush: FLUSH_NONE};
        case (s)
            ST_EXC:                  c = '{stall: STALL_NONE, flush: FLUSH_ALL};
            ST_EXC_WAIT:             c = '{stall: STALL_ALL,  flush: FLUSH_NONE};
            ST_MEM_WAIT:             c = '{stall: STALL_MEM,  flush: FLUSH_W};
            ST_MD_BUSY, ST_MD_TAIL:  c = '{stall: STALL_MD,   flush: FLUSH_M};
            ST_LOAD_USE, ST_BR_DEP:  c = '{stall: STALL_ID,   flush: FLUSH_E};
            ST_IF_WAIT:              c = '{stall: STALL_IF,   flush: FLUSH_D};
            default:                 c = '{stall: STALL_NONE, flush: FLUSH_NONE};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_unit_v2_if.sv
// Pipeline <-> hazard unit bundle. master = pipeline side, slave = hazard unit.
interface hazard_unit_v2_if #(
    parameter int RAW   = 7,
    parameter int CNT_W = 32
);
    logic           exc_req, if_stall, mem_stall;
    logic           md_busy, md_done, branch_d;
    logic [RAW-1:0] rs_d, rt_d, rs_e, rt_e;
    logic [RAW-1:0] wreg_e, wreg_m, wreg_w;
    logic           regwr_e, regwr_m, regwr_w, memrd_e, memrd_m;

    logic [4:0]       stall;
    logic [3:0]       flush;
    logic [1:0]       fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
    logic [CNT_W-1:0] stall_cnt;
    logic [3:0]       state;

    modport master (
        output exc_req, if_stall, mem_stall, md_busy, md_done, branch_d,
               rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
               regwr_e, regwr_m, regwr_w, memrd_e, memrd_m,
        input  stall, flush, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_cnt, state
    );

    modport slave (
        input  exc_req, if_stall, mem_stall, md_busy, md_done, branch_d,
               rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w,
               regwr_e, regwr_m, regwr_w, memrd_e, memrd_m,
        output stall, flush, fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_cnt, state
    );
endinterface

// File: rtl/hazard_unit_v2_fwd_sel.sv
// Bypass select for one source operand: 10 = from MEM, 01 = from WB, 00 = regfile.
module fwd_sel #(
    parameter int RAW = 7
) (
    input  logic           en_i,
    input  logic [RAW-1:0] src_i,
    input  logic           regwr_m_i,
    input  logic           memrd_m_i,
    input  logic [RAW-1:0] wreg_m_i,
    input  logic           regwr_w_i,
    input  logic [RAW-1:0] wreg_w_i,
    output logic [1:0]     fwd_o
);
    always_comb begin
        fwd_o = 2'b00;
        // register 0 is hardwired, and a load in MEM has no data yet to bypass
        if (en_i && src_i != '0) begin
            if (regwr_m_i && !memrd_m_i && wreg_m_i == src_i)
                fwd_o = 2'b10;
            else if (regwr_w_i && wreg_w_i == src_i)
                fwd_o = 2'b01;
        end
    end
endmodule

// File: rtl/hazard_unit_v2.sv
// Pipeline hazard controller: operand forwarding plus a prioritised stall/flush
// FSM covering exceptions, cache waits, mul/div tails and ID-stage dependencies.
module hazard_unit_v2
    import hazard_pkg::*;
#(
    parameter int RAW    = 7,
    parameter int MD_LAT = 2,
    parameter int CNT_W  = 32
) (
    input logic             clk,
    input logic             rst,
    hazard_unit_v2_if.slave hz
);
    hz_state_t        state_q, state_d;
    logic [3:0]       tail_q, tail_d, tail_avail;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use, br_dep, md_stage;
    hz_ctrl_t         ctrl;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic dst_hits(input logic [RAW-1:0] w, a, b);
        return (w != '0) && (w == a || w == b);
    endfunction

    fwd_sel #(.RAW(RAW)) u_fwd_a_d (.en_i(!rst), .src_i(hz.rs_d), .regwr_m_i(hz.regwr_m),
        .memrd_m_i(hz.memrd_m), .wreg_m_i(hz.wreg_m), .regwr_w_i(hz.regwr_w),
        .wreg_w_i(hz.wreg_w), .fwd_o(hz.fwd_a_d));
    fwd_sel #(.RAW(RAW)) u_fwd_b_d (.en_i(!rst), .src_i(hz.rt_d), .regwr_m_i(hz.regwr_m),
        .memrd_m_i(hz.memrd_m), .wreg_m_i(hz.wreg_m), .regwr_w_i(hz.regwr_w),
        .wreg_w_i(hz.wreg_w), .fwd_o(hz.fwd_b_d));
    fwd_sel #(.RAW(RAW)) u_fwd_a_e (.en_i(!rst), .src_i(hz.rs_e), .regwr_m_i(hz.regwr_m),
        .memrd_m_i(hz.memrd_m), .wreg_m_i(hz.wreg_m), .regwr_w_i(hz.regwr_w),
        .wreg_w_i(hz.wreg_w), .fwd_o(hz.fwd_a_e));
    fwd_sel #(.RAW(RAW)) u_fwd_b_e (.en_i(!rst), .src_i(hz.rt_e), .regwr_m_i(hz.regwr_m),
        .memrd_m_i(hz.memrd_m), .wreg_m_i(hz.wreg_m), .regwr_w_i(hz.regwr_w),
        .wreg_w_i(hz.wreg_w), .fwd_o(hz.fwd_b_e));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            tail_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tail_q      <= tail_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        load_use   = hz.memrd_e && hz.regwr_e && dst_hits(hz.wreg_e, hz.rs_d, hz.rt_d);
        br_dep     = hz.branch_d &&
                     ((hz.regwr_e && dst_hits(hz.wreg_e, hz.rs_d, hz.rt_d)) ||
                      (hz.memrd_m && hz.regwr_m && dst_hits(hz.wreg_m, hz.rs_d, hz.rt_d)));
        md_stage   = (state_q == ST_MD_BUSY) || (state_q == ST_MD_TAIL);
        // leaving MD_BUSY behaves as if the counter had just been loaded with MD_LAT
        tail_avail = (state_q == ST_MD_BUSY) ? 4'(MD_LAT) : tail_q;

        state_d = ST_RUN;
        if (rst)                                         state_d = ST_RUN;
        else if (hz.exc_req && (hz.if_stall || hz.mem_stall)) state_d = ST_EXC_WAIT;
        else if (hz.exc_req)                             state_d = ST_EXC;
        else if (hz.mem_stall)                           state_d = ST_MEM_WAIT;
        else if (hz.md_busy && !hz.md_done)              state_d = ST_MD_BUSY;
        else if (md_stage && tail_avail != 4'd0)         state_d = ST_MD_TAIL;
        else if (load_use)                               state_d = ST_LOAD_USE;
        else if (br_dep)                                 state_d = ST_BR_DEP;
        else if (hz.if_stall)                            state_d = ST_IF_WAIT;

        // any state other than MD_TAIL drops the remaining tail for good
        tail_d = (state_d == ST_MD_TAIL) ? tail_avail - 4'd1 : 4'd0;
    end

    always_comb begin
        ctrl        = ctrl_of(state_d);
        stall_cnt_d = ctrl.stall[4] ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    assign hz.stall     = ctrl.stall;
    assign hz.flush     = ctrl.flush;
    assign hz.state     = state_q;
    assign hz.stall_cnt = stall_cnt_q;

endmodule

// File: doc/hazard_unit_v2.md
HAZARD_UNIT_V2 -- requirements
Module: hazard_unit_v2

Interface
REQ-001 SHALL have parameter RAW, default 7, meaning register-address width (GPR, CP0 and HI/LO namespace).
REQ-002 SHALL have parameter MD_LAT, default 2, meaning post-done mul/div tail-stall cycles (0..15).
REQ-003 SHALL have parameter CNT_W, default 32, meaning stall-counter width.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: exc_req  in  1  exception/eret commit; if_stall, mem_stall  in  1 each  cache/bus busy.
REQ-006 SHALL have ports: md_busy  in  1  mul/div running; md_done  in  1  mul/div result valid.
REQ-007 SHALL have ports: branch_d  in  1  ID holds branch/jr; rs_d, rt_d, rs_e, rt_e  in  RAW  source registers.
REQ-008 SHALL have ports: wreg_e, wreg_m, wreg_w  in  RAW  destinations; regwr_e/m/w  in  1; memrd_e, memrd_m  in  1  load.
REQ-009 SHALL have ports: stall  out  5  {F,D,E,M,W}; flush  out  4  {D,E,M,W}; fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e  out  2; stall_cnt  out  CNT_W; state  out  4.

Function
REQ-010 SHALL compute forwarding combinationally; a source equal to 0 always yields 2'b00.
REQ-011 SHALL set fwd_x_e = 2'b10 if regwr_m & !memrd_m & wreg_m==src; else 2'b01 if regwr_w & wreg_w==src; else 2'b00.
REQ-012 SHALL set fwd_x_d by the identical rule using rs_d/rt_d.
REQ-013 SHALL pick next_state by priority each cycle: rst->RUN; exc_req&(if_stall|mem_stall)->EXC_WAIT; exc_req->EXC; mem_stall->MEM_WAIT; md_busy&!md_done->MD_BUSY; state==MD_BUSY|MD_TAIL with tail count>0 ->MD_TAIL; load-use->LOAD_USE; branch dependency->BR_DEP; if_stall->IF_WAIT; else RUN.
REQ-014 SHALL define load-use as memrd_e & regwr_e & wreg_e!=0 & (wreg_e==rs_d | wreg_e==rt_d).
REQ-015 SHALL define branch dependency as branch_d & [(regwr_e & wreg_e matches rs_d/rt_d) | (memrd_m & regwr_m & wreg_m matches rs_d/rt_d)], nonzero registers.
REQ-016 SHALL drive stall/flush combinationally from next_state: RUN 00000/0000; EXC 00000/1111; EXC_WAIT 11111/0000; MEM_WAIT 11110/0001; MD_BUSY and MD_TAIL 11100/0010; LOAD_USE and BR_DEP 11000/0100; IF_WAIT 10000/1000.
REQ-017 SHALL register state <= next_state each cycle; state output encodes RUN=0, EXC=1, EXC_WAIT=2, MEM_WAIT=3, MD_BUSY=4, MD_TAIL=5, LOAD_USE=6, BR_DEP=7, IF_WAIT=8.
REQ-018 SHALL load a 4-bit tail counter with MD_LAT on the MD_BUSY->non-busy transition and decrement it each MD_TAIL cycle; MD_LAT=0 skips MD_TAIL.
REQ-019 SHALL clear the tail counter when any higher-priority state (EXC, EXC_WAIT, MEM_WAIT) preempts MD_TAIL; the tail is not resumed.
REQ-020 SHALL increment stall_cnt on each cycle with stall[F]=1, saturating at all-ones.
REQ-021 SHALL hold EXC_WAIT until both cache stalls drop, then enter EXC if exc_req still high.

Reset
REQ-022 SHALL, while rst=1, force state=RUN, tail counter=0, stall_cnt=0, stall=0, flush=0, all forwards=2'b00.
REQ-023 SHALL abandon any mul/div tail or wait state on rst mid-operation, with no residual stall after rst falls.

Structure
REQ-024 SHALL take the state encodings and stall/flush vector constants from shared package hazard_pkg.
REQ-025 SHALL be a single module, with the forwarding rule in a sub-module fwd_sel instantiated four times.

Verification
REQ-026 SHALL verify: regwr_m=1, wreg_m=5, memrd_m=0, rs_e=5 -> fwd_a_e=10; the same with rs_e=0 -> 00.
REQ-027 SHALL verify: memrd_e=1, regwr_e=1, wreg_e=8, rt_d=8 -> state=6, stall=11000, flush=0100 for one cycle.
REQ-028 SHALL verify: md_busy high 3 cycles, then md_done, MD_LAT=2 -> 3 MD_BUSY cycles, 2 MD_TAIL cycles, then RUN.
REQ-029 SHALL verify: exc_req with mem_stall=1 for 4 cycles -> EXC_WAIT x4, then EXC with flush=1111.
REQ-030 SHALL verify: rst asserted during MD_TAIL -> next cycle state=0, stall_cnt=0; CNT_W=4 with 20 stalled cycles -> stall_cnt=15.
